// File: rtl/mux2_ctrl_pkg.sv
// Shared types and helpers for mux2 select/arbitration control.
// Holds the arbiter state encoding, the select constants for the
// 2:1 mux (d0/d1) and the round-robin winner function.
package mux2_ctrl_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } arb_state_t;

  // mux2 select values
  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

  // Legal parameter bounds
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned HOLD_MIN   = 2;
  localparam int unsigned HOLD_MAX   = 255;

  // Round-robin winner: a lone requester wins, a tie goes to the
  // index that was not served last. With no request the result is
  // unused; last is returned so the expression stays fully defined.
  function automatic logic next_winner(input logic [1:0] req, input logic last);
    logic w;
    case (req)
      2'b01:   w = SEL_D0;
      2'b10:   w = SEL_D1;
      2'b11:   w = ~last;
      default: w = last;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Handshake bundle between the two mux2 requesters and the arbiter.
//   req0/req1 : level requests, held until the requester is done
//   sel       : mux2 select (0=d0, 1=d1)
//   gnt0/gnt1 : requester owns the mux and z is valid
//   z_valid   : gnt0|gnt1
//   busy      : arbiter is not idle
// master = requester side, slave = arbiter side.
interface mux2_arbiter_if;

  logic req0;
  logic req1;
  logic sel;
  logic gnt0;
  logic gnt1;
  logic z_valid;
  logic busy;

  modport master (
    output req0,
    output req1,
    input  sel,
    input  gnt0,
    input  gnt1,
    input  z_valid,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    output sel,
    output gnt0,
    output gnt1,
    output z_valid,
    output busy
  );

endinterface

// File: rtl/mux2_arbiter_settle_timer.sv
// Loadable down-counter that times a settle window of N cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   load : restart the window (counter <= N-1)
//   done : registered, high when the count has reached zero
// A load on edge E followed by N-1 further edges leaves done high,
// so a consumer checking done at each edge acts on edge E+N.
module settle_timer #(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int unsigned CW = (N < 2) ? 1 : $clog2(N + 1);

  logic [CW-1:0] cnt;

  // Down-count with a registered zero flag tracking the next count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b1;
    end else if (load) begin
      cnt  <= CW'(N - 1);
      done <= (N == 1);
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b1;
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter and select sequencer for the shared mux2 output.
// Drives the mux select and only grants once sel has been stable for
// SETTLE_CYCLES cycles, so a requester never samples a resolving z.
// An owner contested for MAX_HOLD consecutive grant cycles is preempted.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mux2_arbiter_if.slave (req0/req1 in; sel, gnt0, gnt1,
//         z_valid, busy out; all outputs registered)
module mux2_arbiter
  import mux2_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned MAX_HOLD      = 8
) (
  input  logic            clk,
  input  logic            rst,
  mux2_arbiter_if.slave   bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  arb_state_t    state;
  logic          last;
  logic [HW-1:0] hold_cnt;

  logic [1:0]    req_c;
  logic          winner_c;
  logic          own_req_c;
  logic          oth_req_c;
  logic          hold_max_c;
  logic          preempt_c;
  logic          load_c;
  logic          settle_done;

  assign req_c = {bus.req1, bus.req0};

  // Arbitration decode from the sampled requests and current owner
  always_comb begin
    winner_c   = next_winner(req_c, last);
    own_req_c  = req_c[bus.sel];
    oth_req_c  = req_c[~bus.sel];
    hold_max_c = (hold_cnt == HW'(MAX_HOLD - 1));
    preempt_c  = 1'b0;
    load_c     = 1'b0;
    if (state == GRANT) begin
      // release takes priority over preemption
      preempt_c = own_req_c && oth_req_c && hold_max_c;
    end
    if ((state == IDLE) && (req_c != 2'b00) && (winner_c != bus.sel)) begin
      load_c = 1'b1;
    end
    if (preempt_c) begin
      load_c = 1'b1;
    end
  end

  // Settle window starts on every sel change
  settle_timer #(
    .N (SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .done (settle_done)
  );

  // Arbiter FSM with registered select, grants and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      hold_cnt    <= '0;
      bus.sel     <= SEL_D0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.z_valid <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c != 2'b00) begin
            bus.busy <= 1'b1;
            if (winner_c == bus.sel) begin
              // mux already points at the winner: no settle needed
              state       <= GRANT;
              hold_cnt    <= '0;
              bus.gnt0    <= (bus.sel == SEL_D0);
              bus.gnt1    <= (bus.sel == SEL_D1);
              bus.z_valid <= 1'b1;
            end else begin
              state   <= SETTLE;
              bus.sel <= winner_c;
            end
          end
        end

        SETTLE: begin
          if (settle_done) begin
            if (own_req_c) begin
              state       <= GRANT;
              hold_cnt    <= '0;
              bus.gnt0    <= (bus.sel == SEL_D0);
              bus.gnt1    <= (bus.sel == SEL_D1);
              bus.z_valid <= 1'b1;
            end else begin
              // requester withdrew during the window; keep sel as is
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end

        GRANT: begin
          if (!own_req_c) begin
            state       <= IDLE;
            last        <= bus.sel;
            hold_cnt    <= '0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.z_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (oth_req_c) begin
            if (preempt_c) begin
              state       <= SETTLE;
              last        <= bus.sel;
              hold_cnt    <= '0;
              bus.sel     <= ~bus.sel;
              bus.gnt0    <= 1'b0;
              bus.gnt1    <= 1'b0;
              bus.z_valid <= 1'b0;
            end else if (!hold_max_c) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end else begin
            hold_cnt <= '0;
          end
        end

        default: begin
          state       <= IDLE;
          bus.gnt0    <= 1'b0;
          bus.gnt1    <= 1'b0;
          bus.z_valid <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
